// File: rtl/mult32x32_req_if.sv
// Valid/ready front end and result FIFO back end around the 32x32 sequential
// multiplier: holds operands, pulses start, tracks busy, queues 64-bit products.
`timescale 1ns/1ps
module mult32x32_req_if #(
  parameter int unsigned RES_DEPTH = 2,
  parameter int unsigned TIMEOUT   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        mult_start,
  input  logic        mult_busy,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [63:0] mult_product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_product,
  output logic        err_timeout,
  output logic [15:0] op_count
);

  localparam int unsigned PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RES_DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_RISE, S_WAIT_FALL} state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_tcnt;
  logic [31:0]   r_a, r_b;
  logic          r_err;
  logic [15:0]   r_ops;
  logic [63:0]   r_mem [RES_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [63:0]   r_head;

  logic          w_in_ready, w_accept, w_push, w_pop, w_tmo_hit, w_mult_start;
  logic [TW-1:0] w_tcnt_inc;
  logic [PW-1:0] w_rptr_nxt;
  logic [63:0]   w_head_nxt;

  assign w_tcnt_inc = r_tcnt + TW'(1);
  assign w_rptr_nxt = r_rptr + PW'(1);
  assign w_pop      = (r_count != CW'(0)) && out_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_accept) w_state_nxt = S_LAUNCH;
      S_LAUNCH:    w_state_nxt = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (mult_busy)      w_state_nxt = S_WAIT_FALL;
        else if (w_tmo_hit) w_state_nxt = S_IDLE;
      end
      S_WAIT_FALL: if (!mult_busy) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Accept only with a free slot, so an in-flight op always has room to land.
  always_comb begin
    w_in_ready   = 1'b0;
    w_accept     = 1'b0;
    w_push       = 1'b0;
    w_tmo_hit    = 1'b0;
    w_mult_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = !reset && (r_count < CW'(RES_DEPTH));
        w_accept   = in_valid && w_in_ready;
      end
      S_LAUNCH:    w_mult_start = 1'b1;
      S_WAIT_RISE: w_tmo_hit    = !mult_busy && (w_tcnt_inc == TW'(TIMEOUT));
      S_WAIT_FALL: w_push       = !mult_busy;
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tcnt <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_err  <= 1'b0;
      r_ops  <= '0;
    end else begin
      if (r_state == S_LAUNCH)                     r_tcnt <= '0;
      else if (r_state == S_WAIT_RISE && !mult_busy) r_tcnt <= w_tcnt_inc;
      if (w_accept) begin
        r_a <= in_a;
        r_b <= in_b;
      end
      if (w_tmo_hit) r_err <= 1'b1;
      if (w_push)    r_ops <= r_ops + 16'd1;
    end
  end

  // Head register keeps its last value once the FIFO drains.
  always_comb begin
    w_head_nxt = r_head;
    if (w_pop && w_push)
      w_head_nxt = (r_count == CW'(1)) ? mult_product : r_mem[w_rptr_nxt];
    else if (w_pop) begin
      if (r_count > CW'(1)) w_head_nxt = r_mem[w_rptr_nxt];
    end else if (w_push && (r_count == CW'(0)))
      w_head_nxt = mult_product;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= mult_product;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= w_rptr_nxt;
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      r_head <= w_head_nxt;
    end
  end

  assign in_ready    = w_in_ready;
  assign mult_start  = w_mult_start;
  assign mult_a      = r_a;
  assign mult_b      = r_b;
  assign out_valid   = (r_count != CW'(0));
  assign out_product = r_head;
  assign err_timeout = r_err;
  assign op_count    = r_ops;

endmodule

// File: tb/tb_mult32x32_req_if.sv
// Bench for mult32x32_req_if: stub multiplier FSM, directed operand pairs,
// result scoreboard popped by an independent output monitor.
`timescale 1ns/1ps
module tb_mult32x32_req_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic        mult_start, mult_busy;
  logic [31:0] mult_a, mult_b;
  logic [63:0] mult_product;
  logic        out_valid, out_ready;
  logic [63:0] out_product;
  logic        err_timeout;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  // Stub multiplier: busy for 4 cycles after start unless told to stay silent.
  int          stub_cnt = 0;
  bit          stub_silent = 1'b0;
  logic [63:0] stub_prod = '0;

  always #5 clk = ~clk;

  mult32x32_req_if #(.RES_DEPTH(2), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mult_start(mult_start), .mult_busy(mult_busy),
    .mult_a(mult_a), .mult_b(mult_b), .mult_product(mult_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .err_timeout(err_timeout), .op_count(op_count)
  );

  always @(posedge clk) begin
    if (reset) stub_cnt <= 0;
    else if (mult_start && !stub_silent) begin
      stub_cnt  <= 4;
      stub_prod <= 64'(mult_a) * 64'(mult_b);
    end else if (stub_cnt != 0) stub_cnt <= stub_cnt - 1;
  end
  assign mult_busy    = (stub_cnt != 0);
  assign mult_product = stub_prod;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_result", out_product, 64'hDEAD_DEAD_DEAD_DEAD);
      else                chk("result", out_product, sb.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns #1 after the accept edge, i.e. in cycle N+1.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] p, input bit exp_push);
    int k;
    in_a = a; in_b = b; in_valid = 1'b1;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 200) begin
      chk("accept_wait", 64'(in_ready), 64'(1));
    end else begin
      @(posedge clk);
      if (exp_push) sb.push_back(p);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic run_timed(input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] p, input logic [15:0] ops);
    issue(a, b, p, 1'b1);
    chk("start_n1", 64'(mult_start), 64'(1));
    chk("in_ready_n1", 64'(in_ready), 64'(0));
    chk("mult_a_n1", 64'(mult_a), 64'(a));
    chk("mult_b_n1", 64'(mult_b), 64'(b));
    for (int c = 2; c <= 6; c++) begin
      step(1);
      chk("start_low", 64'(mult_start), 64'(0));
      chk("out_valid_early", 64'(out_valid), 64'(0));
      chk("mult_a_hold", 64'(mult_a), 64'(a));
      chk("mult_b_hold", 64'(mult_b), 64'(b));
    end
    step(1);
    chk("out_valid_n7", 64'(out_valid), 64'(1));
    chk("out_product_n7", out_product, p);
    chk("op_count_n7", 64'(op_count), 64'(ops));
    chk("in_ready_n7", 64'(in_ready), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    step(3);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_product", out_product, 64'd0);
    chk("rst_op_count", 64'(op_count), 64'(0));
    chk("rst_err", 64'(err_timeout), 64'(0));
    chk("rst_start", 64'(mult_start), 64'(0));
    reset = 1'b0;
    step(1);
    chk("idle_in_ready", 64'(in_ready), 64'(1));

    // Single op, held at the FIFO head then drained
    run_timed(32'd3, 32'd5, 64'd15, 16'd1);
    out_ready = 1'b1;
    step(2);

    // Max operands
    run_timed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 16'd2);
    step(2);

    // Fill the FIFO with the consumer stalled
    out_ready = 1'b0;
    issue(32'd1, 32'd1, 64'd1, 1'b1);
    step(6);
    issue(32'd1, 32'd2, 64'd2, 1'b1);
    step(6);
    chk("full_out_valid", 64'(out_valid), 64'(1));
    chk("full_in_ready", 64'(in_ready), 64'(0));
    chk("full_head", out_product, 64'd1);
    in_a = 32'd1; in_b = 32'd3; in_valid = 1'b1;
    step(3);
    chk("held_in_ready", 64'(in_ready), 64'(0));
    chk("held_mult_b", 64'(mult_b), 64'(2));
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    issue(32'd1, 32'd3, 64'd3, 1'b1);
    // Pop the queued entry on the same edge the third result is pushed
    step(5);
    out_ready = 1'b1;
    step(1);
    chk("pp_out_valid", 64'(out_valid), 64'(1));
    chk("pp_head", out_product, 64'd3);
    chk("pp_op_count", 64'(op_count), 64'(5));
    step(1);
    chk("drained_out_valid", 64'(out_valid), 64'(0));
    chk("drained_product_hold", out_product, 64'd3);

    // Busy never rises
    stub_silent = 1'b1;
    issue(32'd7, 32'd7, 64'd0, 1'b0);
    step(4);
    chk("tmo_err_before", 64'(err_timeout), 64'(0));
    step(1);
    chk("tmo_err", 64'(err_timeout), 64'(1));
    chk("tmo_in_ready", 64'(in_ready), 64'(1));
    chk("tmo_no_push", 64'(out_valid), 64'(0));
    chk("tmo_op_count", 64'(op_count), 64'(5));
    stub_silent = 1'b0;
    issue(32'd6, 32'd7, 64'd42, 1'b1);
    step(7);
    chk("post_tmo_op_count", 64'(op_count), 64'(6));
    chk("err_sticky", 64'(err_timeout), 64'(1));

    // Reset in WAIT_FALL abandons the op
    issue(32'd2, 32'd3, 64'd6, 1'b0);
    step(3);
    reset = 1'b1;
    step(1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_op_count", 64'(op_count), 64'(0));
    chk("mid_rst_err", 64'(err_timeout), 64'(0));
    chk("mid_rst_mult_a", 64'(mult_a), 64'(0));
    chk("mid_rst_mult_b", 64'(mult_b), 64'(0));
    chk("mid_rst_product", out_product, 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
    reset = 1'b0;
    step(1);
    run_timed(32'd4, 32'd5, 64'd20, 16'd1);
    step(3);
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
